// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory access unit.
package mem_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WSETUP,
    ST_WRITE,
    ST_WHOLD,
    ST_RESP
  } state_e;

  localparam logic              RST_RW   = 1'b0;
  localparam logic [WORD_W-1:0] RST_WORD = '0;

  // Request fields held for the duration of one operation.
  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              sext;
    logic [1:0]        lane;
    logic [WORD_W-1:0] wdata;
  } req_t;

  // Misalignment or illegal size; such requests never reach memory.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = lane[0];
      SZ_WORD: err = |lane;
      SZ_ILL:  err = 1'b1;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Little-endian lane extract (with sign/zero extension) and sub-word insert.
module mem_lane_merge
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic              sext,
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data_c,
  output logic [DATA_W-1:0] store_word_c
);

  localparam int unsigned SH_W = 5;

  logic [SH_W-1:0] byte_sh;
  logic [SH_W-1:0] half_sh;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;

  assign byte_sh = {lane, 3'b000};
  assign half_sh = {lane[1], 4'b0000};
  assign byte_v  = 8'(old_word >> byte_sh);
  assign half_v  = 16'(old_word >> half_sh);

  always_comb begin
    load_data_c  = '0;
    store_word_c = old_word;
    case (size)
      SZ_BYTE: begin
        load_data_c  = {{(DATA_W-8){sext & byte_v[7]}}, byte_v};
        store_word_c = (old_word & ~(DATA_W'(8'hFF) << byte_sh))
                     | (DATA_W'(wdata[7:0]) << byte_sh);
      end
      SZ_HALF: begin
        load_data_c  = {{(DATA_W-16){sext & half_v[15]}}, half_v};
        store_word_c = (old_word & ~(DATA_W'(16'hFFFF) << half_sh))
                     | (DATA_W'(wdata[15:0]) << half_sh);
      end
      SZ_WORD: begin
        load_data_c  = old_word;
        store_word_c = wdata;
      end
      default: begin
        load_data_c  = '0;
        store_word_c = old_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Requester-side controller for a combinational-read, level-write 32-bit data memory.
// Sub-word stores are read-modify-write; the RW pulse is framed by a setup and hold cycle.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_RW,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_e            state;
  state_e            state_next;
  req_t              lat;
  logic              accept_c;
  logic              req_err_c;
  logic [DATA_W-1:0] load_data_c;
  logic [DATA_W-1:0] store_word_c;

  assign accept_c  = (state == ST_IDLE) && req_valid && req_ready;
  assign req_err_c = access_err(req_size, req_addr[1:0]);

  mem_lane_merge #(
    .DATA_W (DATA_W)
  ) u_lane_merge (
    .size         (lat.size),
    .lane         (lat.lane),
    .sext         (lat.sext),
    .old_word     (mem_data_out),
    .wdata        (lat.wdata),
    .load_data_c  (load_data_c),
    .store_word_c (store_word_c)
  );

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          if (req_err_c)                          state_next = ST_RESP;
          else if (req_we && req_size == SZ_WORD) state_next = ST_WSETUP;
          else                                    state_next = ST_READ;
        end
      end
      ST_READ:   state_next = lat.we ? ST_WSETUP : ST_RESP;
      ST_WSETUP: state_next = ST_WRITE;
      ST_WRITE:  state_next = ST_WHOLD;
      ST_WHOLD:  state_next = ST_RESP;
      ST_RESP:   if (resp_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State and all registered outputs; memory pins move only on accept and WSETUP entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b0;
      lat         <= '0;
      mem_address <= '0;
      mem_data_in <= RST_WORD;
      mem_RW      <= RST_RW;
      resp_valid  <= 1'b0;
      resp_rdata  <= RST_WORD;
      resp_err    <= 1'b0;
    end else begin
      state     <= state_next;
      req_ready <= (state_next == ST_IDLE);
      mem_RW    <= (state_next == ST_WRITE);
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            lat <= '{we: req_we, size: req_size, sext: req_signed,
                     lane: req_addr[1:0], wdata: req_wdata};
            if (req_err_c) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              mem_address <= req_addr[ADDR_W+1:2];
              if (req_we && req_size == SZ_WORD) mem_data_in <= req_wdata;
            end
          end
        end
        ST_READ: begin
          if (lat.we) begin
            mem_data_in <= store_word_c;
          end else begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_data_c;
          end
        end
        ST_WHOLD: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        ST_RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-array transaction model.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [6:0]  mem_address;
  logic [31:0] mem_data_in;
  logic        mem_RW;
  logic [31:0] mem_data_out;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access_unit #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_RW       (mem_RW),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: combinational read, written while RW is high (sampled on the rising edge).
  logic [31:0] mem [128] = '{default: '0};
  always @(posedge clk) if (mem_RW) mem[mem_address] <= mem_data_in;
  assign mem_data_out = mem[mem_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model: memory as a little-endian byte array ----------------
  logic [7:0] ref_bytes [512] = '{default: '0};

  function automatic int f_nb(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic f_err(input logic [1:0] sz, input int a);
    return (sz == 2'd3) || ((a % f_nb(sz)) != 0);
  endfunction

  function automatic int f_lat(input logic we, input logic [1:0] sz, input logic err);
    if (err) return 0;
    if (!we) return 1;
    return (sz == 2'd2) ? 3 : 4;
  endfunction

  function automatic logic [31:0] f_load(input int a, input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    int nb;
    nb = f_nb(sz);
    v  = '0;
    for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[a + i]) << (8 * i));
    if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  function automatic logic [31:0] f_new(input int a, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] v;
    int base;
    int ba;
    logic [7:0] b;
    base = (a / 4) * 4;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      ba = base + i;
      if (ba >= a && ba < a + f_nb(sz)) b = 8'(wd >> (8 * (ba - a)));
      else                              b = ref_bytes[ba];
      v = v | (32'(b) << (8 * i));
    end
    return v;
  endfunction

  logic        m_rdy, m_busy, m_wr, m_err;
  int          m_cyc, m_lat, m_a, m_nb;
  logic [31:0] m_rdata, m_new, m_wd;
  logic [6:0]  m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdy <= 1'b0; m_busy <= 1'b0; m_wr <= 1'b0; m_err <= 1'b0;
      m_cyc <= 0; m_lat <= 0; m_a <= 0; m_nb <= 0;
      m_rdata <= '0; m_new <= '0; m_wd <= '0; m_idx <= '0;
    end else if (m_busy) begin
      if (m_cyc >= m_lat && resp_ready) begin
        m_busy <= 1'b0;
        m_rdy  <= 1'b1;
        if (m_wr)
          for (int i = 0; i < 4; i++)
            if (i < m_nb) ref_bytes[m_a + i] <= 8'(m_wd >> (8 * i));
      end else begin
        m_cyc <= m_cyc + 1;
      end
    end else if (m_rdy && req_valid) begin
      m_busy  <= 1'b1;
      m_rdy   <= 1'b0;
      m_cyc   <= 0;
      m_err   <= f_err(req_size, int'(req_addr));
      m_lat   <= f_lat(req_we, req_size, f_err(req_size, int'(req_addr)));
      m_wr    <= req_we && !f_err(req_size, int'(req_addr));
      m_rdata <= (req_we || f_err(req_size, int'(req_addr))) ? 32'h0
               : f_load(int'(req_addr), req_size, req_signed);
      m_new   <= f_new(int'(req_addr), req_size, req_wdata);
      m_idx   <= req_addr[8:2];
      m_a     <= int'(req_addr);
      m_nb    <= f_nb(req_size);
      m_wd    <= req_wdata;
    end else begin
      m_rdy <= 1'b1;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic exp_v;
    if (!rst_n) begin
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_mem_RW", 32'(mem_RW), 32'd0);
      check("rst_mem_address", 32'(mem_address), 32'd0);
      check("rst_mem_data_in", mem_data_in, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
    end else begin
      exp_v = m_busy && (m_cyc >= m_lat);
      check("req_ready", 32'(req_ready), 32'(m_rdy));
      check("resp_valid", 32'(resp_valid), 32'(exp_v));
      if (exp_v) begin
        check("resp_rdata", resp_rdata, m_rdata);
        check("resp_err", 32'(resp_err), 32'(m_err));
      end
      check("mem_RW", 32'(mem_RW), 32'(m_busy && m_wr && (m_cyc == m_lat - 2)));
      if (m_busy && m_wr && m_cyc >= m_lat - 3 && m_cyc <= m_lat - 1) begin
        check("wr_mem_address", 32'(mem_address), 32'(m_idx));
        check("wr_mem_data_in", mem_data_in, m_new);
      end
    end
  end

  // ---------------- driver ----------------
  int          last_lat;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic run_txn(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [8:0] a, input logic [31:0] wd,
                         input int hold, input logic noise);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_busy && n < 20);
    check("accept_within_bound", 32'(m_busy), 32'd1);
    if (!m_busy) begin
      req_valid = 1'b0;
      return;
    end
    req_valid = noise;
    if (noise) begin
      req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
      req_addr = 9'($urandom); req_wdata = $urandom;
    end
    n = 0;
    while (!resp_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    last_lat = n;
    check("resp_within_bound", 32'(resp_valid), 32'd1);
    repeat (hold) @(negedge clk);
    last_rdata = resp_rdata;
    last_err   = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_w;
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", 32'(req_ready), 32'd1);

    // Directed sequence on word 4.
    run_txn(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEAD_BEEF, 0, 1'b0);
    check("wst_lat", 32'(last_lat), 32'd3);
    check("wst_err", 32'(last_err), 32'd0);
    check("wst_mem", mem[4], 32'hDEAD_BEEF);
    run_txn(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 0, 1'b0);
    check("wld_lat", 32'(last_lat), 32'd1);
    check("wld_rdata", last_rdata, 32'hDEAD_BEEF);
    run_txn(1'b1, 2'b00, 1'b0, 9'h013, 32'h0000_00A5, 0, 1'b0);
    check("bst_lat", 32'(last_lat), 32'd4);
    check("bst_mem", mem[4], 32'hA5AD_BEEF);
    run_txn(1'b0, 2'b00, 1'b1, 9'h013, 32'h0, 0, 1'b0);
    check("bld_signed", last_rdata, 32'hFFFF_FFA5);
    run_txn(1'b0, 2'b00, 1'b0, 9'h013, 32'h0, 0, 1'b0);
    check("bld_unsigned", last_rdata, 32'h0000_00A5);
    run_txn(1'b1, 2'b01, 1'b0, 9'h012, 32'h0000_1234, 0, 1'b0);
    check("hst_mem", mem[4], 32'h1234_BEEF);
    run_txn(1'b0, 2'b01, 1'b1, 9'h010, 32'h0, 0, 1'b0);
    check("hld_signed", last_rdata, 32'hFFFF_BEEF);
    run_txn(1'b0, 2'b01, 1'b0, 9'h012, 32'h0, 0, 1'b0);
    check("hld_unsigned", last_rdata, 32'h0000_1234);

    // Illegal requests.
    run_txn(1'b0, 2'b10, 1'b0, 9'h011, 32'h0, 0, 1'b0);
    check("err_wld_lat", 32'(last_lat), 32'd0);
    check("err_wld_err", 32'(last_err), 32'd1);
    check("err_wld_rdata", last_rdata, 32'd0);
    run_txn(1'b1, 2'b01, 1'b0, 9'h005, 32'hFFFF_FFFF, 0, 1'b0);
    check("err_hst_err", 32'(last_err), 32'd1);
    check("err_hst_mem", mem[1], 32'd0);
    run_txn(1'b1, 2'b11, 1'b0, 9'h010, 32'h0, 0, 1'b0);
    check("err_sz11_err", 32'(last_err), 32'd1);
    check("err_sz11_mem", mem[4], 32'h1234_BEEF);

    // Back-pressured response with a competing request.
    run_txn(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 5, 1'b1);
    check("hold_rdata", last_rdata, 32'h1234_BEEF);

    for (int k = 0; k < 300; k++)
      run_txn(1'($urandom), 2'($urandom), 1'($urandom), 9'($urandom), $urandom,
              int'($urandom_range(0, 3)), 1'($urandom));

    // Reset during the RW pulse of a word store.
    old_w = mem[16];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 9'h040; req_wdata = ~old_w;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_busy && n < 20);
    req_valid = 1'b0;
    @(negedge clk);
    check("rw_before_reset", 32'(mem_RW), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rw_dropped", 32'(mem_RW), 32'd0);
    check("reset_mid_valid", 32'(resp_valid), 32'd0);
    check("reset_mid_addr", 32'(mem_address), 32'd0);
    check("reset_mid_din", mem_data_in, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_mid_reset", 32'(req_ready), 32'd1);
    check("no_resp_after_reset", 32'(resp_valid), 32'd0);
    check("word_unchanged_after_reset", mem[16], old_w);

    for (int w = 0; w < 128; w++)
      check("final_mem_word", mem[w],
            {ref_bytes[w*4+3], ref_bytes[w*4+2], ref_bytes[w*4+1], ref_bytes[w*4]});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Requester-side controller for the 128 x 32 data memory, which reads combinationally and writes while its RW input is high. It accepts byte, half-word and word load/store requests from the datapath over a valid/ready handshake and drives the memory's address, data_in and RW pins. Sub-word stores use a read-modify-write sequence. The unit returns load data with sign or zero extension, and flags misaligned or illegal requests without touching memory.

Parameters:
ADDR_W, 7, word-address width; memory depth is 2**ADDR_W words
DATA_W, 32, memory word width; must be 32

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; a request is accepted on the edge where req_valid and req_ready are both high
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  load sign-extend (1) or zero-extend (0); ignored for stores
req_addr  in  ADDR_W+2  byte address, little-endian
req_wdata  in  DATA_W  store data, right-aligned
resp_valid  out  1  response present; held until resp_ready
resp_ready  in  1  consumer accepts the response
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
resp_err  out  1  misaligned access or size 11
mem_address  out  ADDR_W  registered; drives the memory address
mem_data_in  out  DATA_W  registered; drives the memory data_in
mem_RW  out  1  registered; 1 = write
mem_data_out  in  DATA_W  memory read data, combinational

Behaviour:
- Reset (asynchronous, rst_n low):
  - Forces state IDLE.
  - mem_RW=0, mem_address=0, mem_data_in=0.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - No request is accepted while rst_n is low.
- Address decode:
  - Word index = req_addr[ADDR_W+1:2].
  - Byte lane = req_addr[1:0]; lane 0 is bits 7:0.
  - Half lane = req_addr[1].
- Errors:
  - Half access requires addr[0]=0; word access requires addr[1:0]=0; size 11 is always illegal.
  - Any violation goes IDLE -> RESP with resp_err=1 and rdata=0; memory is never driven.
- States: IDLE, READ, WSETUP, WRITE, WHOLD, RESP.
- Transitions:
  - Accept in IDLE: latch request fields; mem_address <= word index.
  - Load: IDLE -> READ -> RESP.
  - Word store: IDLE -> WSETUP -> WRITE -> WHOLD -> RESP; mem_data_in <= req_wdata on accept.
  - Sub-word store: IDLE -> READ -> WSETUP -> WRITE -> WHOLD -> RESP.
- READ: mem_RW=0. mem_data_out is captured on the exiting edge: for loads, lane-extracted and extended into resp_rdata; for sub-word stores, merged with the store data into mem_data_in on entry to WSETUP.
- Write timing:
  - mem_RW=1 only in WRITE, for exactly one cycle.
  - mem_address and mem_data_in are constant across WSETUP, WRITE and WHOLD, i.e. one full cycle either side of the RW pulse.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until the edge where resp_ready=1, then IDLE.
  - req_ready=0 throughout RESP; no request overlap.
- Latency: cycle 0 is the cycle after the accepting edge. resp_valid first goes high in:
  - error: cycle 0
  - load: cycle 1
  - word store: cycle 3
  - sub-word store: cycle 4
- mem_address and mem_data_in change only on acceptance and on WSETUP entry.
- Reset mid-operation:
  - The operation is abandoned with no response, and mem_RW drops immediately.
  - If rst_n falls during WRITE, the target word holds either the old or the new value; no other word is affected.

Decomposition:
- Package mem_pkg:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum.
  - Reset constants.
- Sub-module mem_lane_merge: purely combinational, built on the same lane decode.
  - Extract with extension, for loads.
  - Insert of store data into the old word, for stores.
- FSM and registers live in mem_access_unit.

Test Plan:
- Word store to addr 0x010, wdata 0xDEADBEEF -> one-cycle mem_RW pulse with mem_address=4 and mem_data_in=0xDEADBEEF stable from the cycle before to the cycle after; resp in cycle 3, err=0. Word load from 0x010 -> rdata 0xDEADBEEF in cycle 1.
- Byte store to 0x013, wdata 0x000000A5, over 0xDEADBEEF -> memory word 0xA5ADBEEF; resp in cycle 4. Signed byte load from 0x013 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
- Half store to 0x012, wdata 0x1234 -> word 0x1234BEEF. Signed half load from 0x010 -> 0xFFFFBEEF; unsigned half load from 0x012 -> 0x00001234.
- Word load from 0x011, half store to 0x005, any size=11 -> resp_err=1, rdata=0 in cycle 0; mem_RW never high; memory unchanged.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0, concurrent req_valid ignored; the next request is accepted only after the response handshake.
- Drop rst_n during WRITE -> mem_RW=0 immediately, all outputs at reset values, no response; req_ready=1 on the first edge after release.
